axi_ar_burst_splitter: RTL

- Upstream feeder for the AXI5 manager interface: accepts one read command (start address, byte length, ID) and issues it as a sequence of AXI AR INCR bursts.
- Each burst fits in one naturally aligned MAX_TRANSACTION_BYTES window, so it never exceeds the interface's Max_Transaction_Bytes limit and never crosses a 4KB boundary.
- Drives araddr/arlen/arsize/arburst/arid/arvalid into axi_if and takes arready back.

---
 rtl/axi_burst_pkg.sv | 22 ++
 rtl/axi_chunk_calc.sv | 32 +++
 rtl/axi_ar_burst_splitter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/axi_burst_pkg.sv
// Shared AXI burst types and helpers for the AR/AW burst splitters.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Bytes-per-beat to AxSIZE encoding.
  function automatic logic [2:0] size_of(input int unsigned nbytes);
    int unsigned lg;
    lg = $clog2(nbytes);
    return lg[2:0];
  endfunction

endpackage

// File: rtl/axi_chunk_calc.sv
// Size of the next INCR burst: clipped to the end of the current naturally
// aligned MTB window and to the bytes still owed.
module axi_chunk_calc #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int BPB        = 4,
  parameter int MTB        = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  remaining_i,
  output logic [LEN_WIDTH-1:0]  bytes_o,
  output logic [7:0]            arlen_o
);

  localparam int SHIFT = $clog2(BPB);

  logic [ADDR_WIDTH-1:0] offs;
  logic [LEN_WIDTH-1:0]  room;
  logic [LEN_WIDTH-1:0]  beats_m1;
  logic [LEN_WIDTH+7:0]  beats_wide;
  logic                  unused_hi;

  assign offs       = addr_i & ADDR_WIDTH'(MTB - 1);
  assign room       = LEN_WIDTH'(MTB) - LEN_WIDTH'(offs);
  assign bytes_o    = (remaining_i < room) ? remaining_i : room;
  assign beats_m1   = (bytes_o >> SHIFT) - LEN_WIDTH'(1);
  // Bytes never exceed 256*BPB, so only the low 8 bits of the beat count matter.
  assign beats_wide = {8'b0, beats_m1};
  assign arlen_o    = beats_wide[7:0];
  assign unused_hi  = ^beats_wide[LEN_WIDTH+7:8];

endmodule

// File: rtl/axi_ar_burst_splitter.sv
// Splits one read command into a train of AR INCR bursts, each confined to a
// naturally aligned MAX_TRANSACTION_BYTES window.
module axi_ar_burst_splitter
  import axi_burst_pkg::*;
#(
  parameter int ADDR_WIDTH            = 16,
  parameter int DATA_WIDTH            = 32,
  parameter int ID_WIDTH              = 4,
  parameter int MAX_TRANSACTION_BYTES = 64,
  parameter int LEN_WIDTH             = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [ID_WIDTH-1:0]   arid,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam logic [2:0] ARSIZE = size_of(BPB);

  state_e                state_q;
  logic                  cmd_ready_q, arvalid_q, cmd_err_q, busy_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [LEN_WIDTH-1:0]  rem_q, bytes_q;

  logic [ADDR_WIDTH-1:0] nxt_addr_d, calc_addr;
  logic [LEN_WIDTH-1:0]  nxt_rem_d, calc_rem, calc_bytes;
  logic [7:0]            calc_len;
  logic                  legal;

  assign legal = (cmd_len != '0)
              && ((cmd_len & LEN_WIDTH'(BPB - 1)) == '0)
              && ((cmd_addr & ADDR_WIDTH'(BPB - 1)) == '0);

  assign nxt_addr_d = araddr_q + ADDR_WIDTH'(bytes_q);
  assign nxt_rem_d  = rem_q - bytes_q;

  // One calculator serves both the first chunk (from the command) and every
  // following chunk (from the post-handshake address/remaining).
  assign calc_addr = (state_q == IDLE) ? cmd_addr : nxt_addr_d;
  assign calc_rem  = (state_q == IDLE) ? cmd_len  : nxt_rem_d;

  axi_chunk_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH),
    .BPB       (BPB),
    .MTB       (MAX_TRANSACTION_BYTES)
  ) u_calc (
    .addr_i     (calc_addr),
    .remaining_i(calc_rem),
    .bytes_o    (calc_bytes),
    .arlen_o    (calc_len)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arid_q      <= '0;
      rem_q       <= '0;
      bytes_q     <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            if (legal) begin
              araddr_q    <= cmd_addr;
              rem_q       <= cmd_len;
              arid_q      <= cmd_id;
              bytes_q     <= calc_bytes;
              arlen_q     <= calc_len;
              arvalid_q   <= 1'b1;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              state_q     <= ISSUE;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (arready) begin
            if (nxt_rem_d == '0) begin
              arvalid_q   <= 1'b0;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              araddr_q <= nxt_addr_d;
              rem_q    <= nxt_rem_d;
              bytes_q  <= calc_bytes;
              arlen_q  <= calc_len;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arid      = arid_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = busy_q;
  assign arsize    = ARSIZE;
  assign arburst   = INCR;

endmodule
